// File: rtl/led_sweep_ctrl_pkg.sv
// Shared types and constants for the LED sweep sequencer.
package led_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_SEED  = 3'd2,
      ST_LEFT  = 3'd3,
      ST_RIGHT = 3'd4
   } state_t;

   localparam logic [1:0] FN_HOLD  = 2'b00;
   localparam logic [1:0] FN_LEFT  = 2'b01;
   localparam logic [1:0] FN_RIGHT = 2'b10;

   localparam logic [7:0] SEED_LO = 8'h01;
   localparam logic [7:0] SEED_HI = 8'h80;

endpackage

// File: rtl/led_sweep_ctrl_if.sv
// Handshake between board top level / datapath (master) and the sweep sequencer (slave).
interface led_sweep_ctrl_if;

   logic       start;
   logic       stop;
   logic       mode;
   logic [7:0] dp_o;
   logic       sel_i;
   logic       sel_ii;
   logic       reg_cl;
   logic       ld;
   logic [1:0] funcc;
   logic       busy;
   logic       fault;
   logic [7:0] sweep_cnt;

   modport master (
      output start, stop, mode, dp_o,
      input  sel_i, sel_ii, reg_cl, ld, funcc, busy, fault, sweep_cnt
   );

   modport slave (
      input  start, stop, mode, dp_o,
      output sel_i, sel_ii, reg_cl, ld, funcc, busy, fault, sweep_cnt
   );

endinterface

// File: rtl/led_sweep_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle shift-step strobe every TICK_DIV enabled cycles.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic cl,
   input  logic en,
   input  logic reload,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] r_cnt;

   // Count down while enabled; restart from the top on wrap, on request and in reset
   always_ff @(posedge clk) begin
      if (cl || reload) begin
         r_cnt <= LAST;
      end else if (en) begin
         if (r_cnt == '0) r_cnt <= LAST;
         else             r_cnt <= r_cnt - ONE;
      end
   end

   assign tick = en && (r_cnt == '0);

endmodule

// File: rtl/led_sweep_ctrl.sv
// Sequencer for the 8-bit LED shift datapath: one lit LED sweeps left/right (bounce)
// or left with reload (ring); counts sweeps and recovers from a corrupted pattern.
module led_sweep_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 1000
) (
   input  logic             clk,
   input  logic             cl,
   led_sweep_ctrl_if.slave  bus
);

   state_t     r_state;
   logic       r_mode;
   logic       r_fault;
   logic [7:0] r_sweep_cnt;

   logic       w_tick;
   logic       w_run;
   logic       w_reload;
   logic       w_onehot;
   logic       w_accept;

   state_t     w_next;
   logic       w_sel_i;
   logic       w_sel_ii;
   logic       w_reg_cl;
   logic       w_ld;
   logic [1:0] w_funcc;
   logic       w_cnt_inc;
   logic       w_fault_set;

   function automatic logic is_one_hot(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
   endfunction

   assign w_run    = (r_state == ST_LEFT) || (r_state == ST_RIGHT);
   assign w_reload = (r_state == ST_SEED);
   assign w_onehot = is_one_hot(bus.dp_o);
   assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.stop;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .cl     (cl),
      .en     (w_run),
      .reload (w_reload),
      .tick   (w_tick)
   );

   // Decode datapath controls and next state from {state, tick, feedback}
   always_comb begin
      w_next      = r_state;
      w_sel_i     = 1'b0;
      w_sel_ii    = 1'b0;
      w_reg_cl    = 1'b0;
      w_ld        = 1'b0;
      w_funcc     = FN_HOLD;
      w_cnt_inc   = 1'b0;
      w_fault_set = 1'b0;
      if (bus.stop && (r_state != ST_IDLE)) begin
         // Abort: every control stays low so the register keeps its last value
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
               w_reg_cl = 1'b1;
               w_next   = ST_SEED;
            end
            ST_SEED: begin
               // sel_ii=0, sel_i=0 selects the low seed 8'h01
               w_ld   = 1'b1;
               w_next = ST_LEFT;
            end
            ST_LEFT: begin
               if (w_tick) begin
                  if (!w_onehot) begin
                     w_fault_set = 1'b1;
                     w_next      = ST_CLEAR;
                  end else if (bus.dp_o != SEED_HI) begin
                     w_ld     = 1'b1;
                     w_sel_ii = 1'b1;
                     w_funcc  = FN_LEFT;
                  end else if (!r_mode) begin
                     w_ld     = 1'b1;
                     w_sel_ii = 1'b1;
                     w_funcc  = FN_RIGHT;
                     w_next   = ST_RIGHT;
                  end else begin
                     // Ring wrap: reload the low seed instead of shifting
                     w_ld      = 1'b1;
                     w_cnt_inc = 1'b1;
                  end
               end
            end
            ST_RIGHT: begin
               if (w_tick) begin
                  if (!w_onehot) begin
                     w_fault_set = 1'b1;
                     w_next      = ST_CLEAR;
                  end else if (bus.dp_o != SEED_LO) begin
                     w_ld     = 1'b1;
                     w_sel_ii = 1'b1;
                     w_funcc  = FN_RIGHT;
                  end else begin
                     w_ld      = 1'b1;
                     w_sel_ii  = 1'b1;
                     w_funcc   = FN_LEFT;
                     w_cnt_inc = 1'b1;
                     w_next    = ST_LEFT;
                  end
               end
            end
            default: begin
               w_next = ST_IDLE;
            end
         endcase
      end
   end

   // Advance state and keep the mode latch, sticky fault and sweep counter
   always_ff @(posedge clk) begin
      if (cl) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_fault     <= 1'b0;
         r_sweep_cnt <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mode  <= bus.mode;
            r_fault <= 1'b0;
         end
         if (w_fault_set) r_fault <= 1'b1;
         if (w_cnt_inc)   r_sweep_cnt <= r_sweep_cnt + 8'h01;
      end
   end

   assign bus.sel_i     = w_sel_i;
   assign bus.sel_ii    = w_sel_ii;
   assign bus.reg_cl    = w_reg_cl;
   assign bus.ld        = w_ld;
   assign bus.funcc     = w_funcc;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.fault     = r_fault;
   assign bus.sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Bench for led_sweep_ctrl with a behavioural model of the 8-bit shift datapath on dp_o.
module tb_led_sweep_ctrl;

   localparam int TD = 4;

   logic clk = 1'b0;
   logic cl  = 1'b1;

   always #5 clk = ~clk;

   led_sweep_ctrl_if bus ();

   led_sweep_ctrl #(
      .TICK_DIV (TD)
   ) dut (
      .clk (clk),
      .cl  (cl),
      .bus (bus)
   );

   // Datapath model: seed mux, shifter and load/clear register
   logic [7:0] dp_reg  = 8'h00;
   logic       ovr_en  = 1'b0;
   logic [7:0] ovr_val = 8'h00;

   always @(posedge clk) begin
      if (bus.reg_cl) begin
         dp_reg <= 8'h00;
      end else if (bus.ld) begin
         if (!bus.sel_ii) dp_reg <= bus.sel_i ? 8'h80 : 8'h01;
         else if (bus.funcc == 2'b01) dp_reg <= dp_reg << 1;
         else if (bus.funcc == 2'b10) dp_reg <= dp_reg >> 1;
      end
   end

   assign bus.dp_o = ovr_en ? ovr_val : dp_reg;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_vec++;
      n_miss++;
      $display("FAIL %s: no response within cycle budget", nm);
   endtask

   // Move to one time unit past the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Wait for the next load strobe, report its function and the idle cycles before it
   task automatic next_load(output logic [1:0] fn, output int gap, output bit ok);
      ok  = 1'b0;
      gap = 0;
      fn  = 2'b00;
      for (int i = 0; i < 3 * TD; i++) begin
         if (bus.ld) begin
            fn = bus.funcc;
            ok = 1'b1;
            cyc();
            return;
         end
         gap++;
         cyc();
      end
   endtask

   task automatic run_ticks(input int n, output bit saw_right);
      logic [1:0] fn;
      int         gap;
      bit         ok;
      saw_right = 1'b0;
      for (int k = 0; k < n; k++) begin
         next_load(fn, gap, ok);
         if (!ok) begin
            timeout("tick wait");
            return;
         end
         if (fn == 2'b10) saw_right = 1'b1;
      end
   endtask

   typedef struct packed {
      logic       cl;
      logic       start;
      logic       stop;
      logic       mode;
      logic       busy;
      logic       reg_cl;
      logic       ld;
      logic       sel_ii;
      logic [1:0] fn;
      logic [7:0] dp;
   } vec_t;

   vec_t tbl [10];

   // Reference model state (position/direction view of the sweep)
   int         m_phase;
   bit         m_ring;
   bit         m_right;
   int         m_pos;
   int         m_wait;
   logic [7:0] m_cnt;
   bit         m_fault;

   initial begin
      logic [1:0] fn;
      int         gap;
      bit         ok;
      bit         saw_r;
      bit         saw_ld;
      bit         got;
      logic       e_rc, e_ld, e_sii, e_busy;
      logic [1:0] e_fn;
      int         r;

      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;

      // Reset state
      cl = 1'b1;
      repeat (2) cyc();
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset fault", 32'(bus.fault), 32'h0);
      check("reset sweep_cnt", 32'(bus.sweep_cnt), 32'h0);
      check("reset ctl", 32'({bus.ld, bus.reg_cl, bus.sel_i, bus.sel_ii, bus.funcc}), 32'h0);
      cl = 1'b0;

      // Table: start+stop, then a bounce start through CLEAR, SEED and the first tick
      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 8'h01};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h02};
      for (int i = 0; i < 10; i++) begin
         cl        = tbl[i].cl;
         bus.start = tbl[i].start;
         bus.stop  = tbl[i].stop;
         bus.mode  = tbl[i].mode;
         #1;
         check($sformatf("table[%0d]", i),
               32'({bus.busy, bus.reg_cl, bus.ld, bus.sel_ii, bus.funcc, bus.dp_o}),
               32'({tbl[i].busy, tbl[i].reg_cl, tbl[i].ld, tbl[i].sel_ii, tbl[i].fn, tbl[i].dp}));
         cyc();
      end
      bus.start = 1'b0;
      bus.mode  = 1'b0;

      // Bounce: 1 tick done; 6 more reach 8'h80
      run_ticks(6, saw_r);
      check("bounce dp after 7", 32'(bus.dp_o), 32'h80);
      next_load(fn, gap, ok);
      check("bounce turn fn", 32'({ok, fn}), 32'({1'b1, 2'b10}));
      check("tick spacing", 32'(gap), 32'(TD - 1));
      run_ticks(6, saw_r);
      check("bounce dp after 14", 32'(bus.dp_o), 32'h01);
      check("bounce cnt after 14", 32'(bus.sweep_cnt), 32'h0);
      run_ticks(1, saw_r);
      check("bounce dp after 15", 32'(bus.dp_o), 32'h02);
      check("bounce cnt after 15", 32'(bus.sweep_cnt), 32'h1);

      // Stop at 8'h10
      got = 1'b0;
      for (int i = 0; i < 6 * TD; i++) begin
         if (bus.dp_o == 8'h10) begin
            got = 1'b1;
            break;
         end
         cyc();
      end
      if (!got) timeout("reach 8'h10");
      bus.stop = 1'b1;
      #1;
      check("stop ld", 32'(bus.ld), 32'h0);
      cyc();
      bus.stop = 1'b0;
      #1;
      check("stop busy", 32'(bus.busy), 32'h0);
      repeat (2 * TD) cyc();
      check("stop dp holds", 32'(bus.dp_o), 32'h10);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      #1;
      check("restart clear", 32'({bus.busy, bus.reg_cl}), 32'h3);

      // Fault recovery
      cyc();
      cyc();
      check("restart dp", 32'(bus.dp_o), 32'h01);
      run_ticks(2, saw_r);
      ovr_en  = 1'b1;
      ovr_val = 8'h11;
      #1;
      saw_ld = 1'b0;
      got    = 1'b0;
      for (int i = 0; i < 3 * TD; i++) begin
         if (bus.ld) saw_ld = 1'b1;
         cyc();
         if (bus.fault) begin
            got = 1'b1;
            break;
         end
      end
      ovr_en = 1'b0;
      if (!got) timeout("fault set");
      #1;
      check("fault no load", 32'(saw_ld), 32'h0);
      check("fault clear", 32'({bus.fault, bus.reg_cl}), 32'h3);
      cyc();
      check("fault seed", 32'({bus.ld, bus.sel_ii}), 32'h2);
      cyc();
      check("fault resume dp", 32'(bus.dp_o), 32'h01);
      run_ticks(1, saw_r);
      check("fault sticky run", 32'({bus.fault, bus.dp_o}), 32'h102);
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      #1;
      check("fault sticky idle", 32'({bus.busy, bus.fault}), 32'h1);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      #1;
      check("fault cleared by start", 32'(bus.fault), 32'h0);

      // Ring: sweep_cnt was 1
      cyc();
      cyc();
      run_ticks(7, saw_r);
      check("ring dp 80", 32'(bus.dp_o), 32'h80);
      run_ticks(1, saw_r);
      check("ring reload", 32'({bus.sweep_cnt, bus.dp_o}), 32'h0201);
      run_ticks(16, saw_r);
      check("ring 24 ticks", 32'({bus.sweep_cnt, bus.dp_o}), 32'h0401);
      check("ring never right", 32'(saw_r), 32'h0);

      // sweep_cnt wrap
      run_ticks(251 * 8, saw_r);
      check("cnt FF", 32'(bus.sweep_cnt), 32'hFF);
      run_ticks(8, saw_r);
      check("cnt wrap", 32'(bus.sweep_cnt), 32'h00);

      // cl pulse while sweeping right
      bus.stop = 1'b1;
      cyc();
      bus.stop  = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      cyc();
      cyc();
      run_ticks(15, saw_r);
      run_ticks(7, saw_r);
      check("right before cl", 32'({bus.busy, bus.sweep_cnt, bus.dp_o}), 32'h10140);
      cl = 1'b1;
      cyc();
      cl = 1'b0;
      #1;
      check("cl in right", 32'({bus.busy, bus.fault, bus.sweep_cnt, bus.dp_o}), 32'h0040);

      // Randomized run against the position/direction model
      cl = 1'b1;
      repeat (2) cyc();
      m_phase = 0; m_ring = 0; m_right = 0; m_pos = 0; m_wait = TD - 1;
      m_cnt = 8'h00; m_fault = 0;
      for (int c = 0; c < 3000; c++) begin
         r         = int'($urandom_range(0, 999));
         cl        = (r < 3);
         bus.stop  = (r >= 3) && (r < 10);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.mode  = $urandom_range(0, 1) != 0;
         #1;
         e_busy = (m_phase != 0);
         e_rc = 0; e_ld = 0; e_sii = 0; e_fn = 2'b00;
         if (m_phase != 0 && !bus.stop) begin
            if (m_phase == 1) e_rc = 1;
            else if (m_phase == 2) e_ld = 1;
            else if (m_wait == 0) begin
               e_ld = 1;
               if (!m_right) begin
                  if (m_pos < 7) begin e_sii = 1; e_fn = 2'b01; end
                  else if (!m_ring) begin e_sii = 1; e_fn = 2'b10; end
               end else begin
                  e_sii = 1;
                  e_fn  = (m_pos > 0) ? 2'b10 : 2'b01;
               end
            end
         end
         check("rand ctl",
               32'({bus.busy, bus.fault, bus.sweep_cnt, bus.ld, bus.reg_cl, bus.sel_i, bus.sel_ii, bus.funcc}),
               32'({e_busy, m_fault, m_cnt, e_ld, e_rc, 1'b0, e_sii, e_fn}));
         if (m_phase == 3) check("rand dp", 32'(bus.dp_o), 32'h1 << m_pos);
         if (cl) begin
            m_phase = 0; m_ring = 0; m_cnt = 8'h00; m_fault = 0;
         end else if (m_phase == 0) begin
            if (bus.start && !bus.stop) begin m_phase = 1; m_ring = bus.mode; m_fault = 0; end
         end else if (bus.stop) begin
            m_phase = 0;
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (m_phase == 2) begin
            m_phase = 3; m_pos = 0; m_right = 0; m_wait = TD - 1;
         end else if (m_wait > 0) begin
            m_wait--;
         end else begin
            m_wait = TD - 1;
            if (!m_right) begin
               if (m_pos < 7) m_pos++;
               else if (m_ring) begin m_pos = 0; m_cnt = m_cnt + 8'h01; end
               else begin m_right = 1; m_pos = 6; end
            end else begin
               if (m_pos > 0) m_pos--;
               else begin m_right = 0; m_pos = 1; m_cnt = m_cnt + 8'h01; end
            end
         end
         cyc();
      end
      cl        = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at 2 ms, expected to have finished");
      $fatal(1, "watchdog expired");
   end

endmodule
